// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one outstanding memory read at a time and
// buffers {pc, data} results in a 2-entry FIFO toward decode.
module fetch_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  pc_in,
    output logic              pc_en,
    output logic              mem_req_valid,
    output logic [WIDTH-1:0]  mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [WIDTH-1:0]  inst_pc,
    input  logic              inst_ready,
    input  logic              flush
);

    localparam int unsigned DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  pend_pc;
    logic              drop;
    logic [WIDTH-1:0]  fifo_pc   [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              accept;
    logic              push;
    logic              pop;

    assign accept = mem_req_valid && mem_req_ready;
    assign push   = (state == WAIT) && mem_rsp_valid && !drop && !flush;
    assign pop    = inst_valid && inst_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Credit check: only request when the FIFO has room for the response.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if ((count < 2'd2) && !flush) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (accept) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request channel and PC advance are combinational so the counter steps on the accepting edge.
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        pc_en         = 1'b0;
        if ((state == REQ) && !flush) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = pc_in;
            pc_en         = mem_req_ready;
        end
    end

    // A flush while waiting marks the in-flight response for discard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_pc <= '0;
            drop    <= 1'b0;
        end else begin
            if (accept) begin
                pend_pc <= pc_in;
            end
            if (state == WAIT) begin
                drop <= mem_rsp_valid ? 1'b0 : (drop | flush);
            end else begin
                drop <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= pend_pc;
            fifo_data[wr_ptr] <= mem_rsp_data;
        end
    end

    assign inst_valid = (count != 2'd0);
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr] : '0;
    assign inst_data  = inst_valid ? fifo_data[rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected {pc, data}
// entries; a negedge monitor pops and compares on every instruction handshake.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = 32'd0;
    logic        pc_en;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        flush;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t      exp_q[$];
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          n_pops    = 0;
    int          pc_en_cnt = 0;
    int          pc_base   = 0;
    int          pops_base = 0;

    logic        pc_ld = 1'b0;
    logic [31:0] pc_ld_val = 32'd0;
    logic        rsp_en = 1'b1;
    logic        m_rsp_valid = 1'b0;
    logic [31:0] m_rsp_data = 32'd0;
    logic        a_pend = 1'b0;
    logic        a_rsp_valid = 1'b0;
    logic [31:0] a_addr = 32'd0;
    logic [31:0] a_rsp_data = 32'd0;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_addr = 32'd0;

    fetch_unit #(.WIDTH(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_in         (pc_in),
        .pc_en         (pc_en),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .flush         (flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] addr);
        case (addr)
            32'h20:  return 32'hAAAA_0000;
            32'h24:  return 32'hBBBB_0000;
            default: return 32'hD000_0000 | addr;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_inst(input logic [31:0] pc, input logic [31:0] data);
        entry_t e;
        e.pc   = pc;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Upstream PC counter model
    always @(posedge clk) begin
        if (pc_ld) begin
            pc_in <= pc_ld_val;
        end else if (pc_en) begin
            pc_in <= pc_in + 32'd4;
        end
        if (!rst && pc_en) begin
            pc_en_cnt <= pc_en_cnt + 1;
        end
    end

    // Memory model: 1-cycle response, or held back while rsp_en is low
    always @(posedge clk) begin
        a_rsp_valid <= 1'b0;
        if (rst) begin
            a_pend <= 1'b0;
        end else if (a_pend) begin
            if (rsp_en) begin
                a_rsp_valid <= 1'b1;
                a_rsp_data  <= data_of(a_addr);
                a_pend      <= 1'b0;
            end
        end else if (mem_req_valid && mem_req_ready) begin
            if (rsp_en) begin
                a_rsp_valid <= 1'b1;
                a_rsp_data  <= data_of(mem_req_addr);
            end else begin
                a_pend <= 1'b1;
                a_addr <= mem_req_addr;
            end
        end
    end

    assign mem_rsp_valid = a_rsp_valid | m_rsp_valid;
    assign mem_rsp_data  = a_rsp_valid ? a_rsp_data : m_rsp_data;

    // Monitor: handshake protocol checks and scoreboard pop
    always @(negedge clk) begin
        if (!rst) begin
            check("pc_en_vs_handshake", 64'(pc_en), 64'(mem_req_valid && mem_req_ready));
            if (stall_prev && !flush) begin
                check("req_hold_valid", 64'(mem_req_valid), 64'd1);
                check("req_hold_addr", 64'(mem_req_addr), 64'(stall_addr));
            end
            if (inst_valid && inst_ready) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_inst: got pc %0h data %0h, expected none", inst_pc, inst_data);
                end else begin
                    entry_t e;
                    e = exp_q.pop_front();
                    check("inst_pc", 64'(inst_pc), 64'(e.pc));
                    check("inst_data", 64'(inst_data), 64'(e.data));
                end
            end
        end
        stall_prev = !rst && mem_req_valid && !mem_req_ready;
        stall_addr = mem_req_addr;
    end

    task automatic start_test(input logic [31:0] pc);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        flush       = 1'b0;
        m_rsp_valid = 1'b0;
        rst         = 1'b1;
        pc_ld       = 1'b1;
        pc_ld_val   = pc;
        tick();
        tick();
        rst       = 1'b0;
        pc_ld     = 1'b0;
        pc_base   = pc_en_cnt;
        pops_base = n_pops;
    endtask

    task automatic wait_pc_en(input int target, input int budget, input string name);
        int i = 0;
        while ((pc_en_cnt - pc_base) < target && i < budget) begin
            tick();
            i++;
        end
        check(name, 64'(pc_en_cnt - pc_base), 64'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_req_ready = 1'b1;
        inst_ready    = 1'b0;
        flush         = 1'b0;

        // Reset values with a nonzero PC and ready asserted
        rst = 1'b1; pc_ld = 1'b1; pc_ld_val = 32'h1234;
        tick(); tick();
        @(negedge clk);
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_pc_en", 64'(pc_en), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst_data", 64'(inst_data), 64'd0);
        check("rst_inst_pc", 64'(inst_pc), 64'd0);
        check("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);

        // Steady stream 0,4,8
        mem_req_ready = 1'b1; inst_ready = 1'b1; rsp_en = 1'b1;
        start_test(32'h0);
        expect_inst(32'h0, 32'hD000_0000);
        expect_inst(32'h4, 32'hD000_0004);
        expect_inst(32'h8, 32'hD000_0008);
        @(negedge clk);
        check("first_req_delay", 64'(mem_req_valid), 64'd0);
        wait_pc_en(3, 30, "stream_req_count");
        mem_req_ready = 1'b0;
        repeat (6) tick();
        check("stream_pops", 64'(n_pops - pops_base), 64'd3);
        check("stream_pc_en", 64'(pc_en_cnt - pc_base), 64'd3);

        // Backpressure: two entries fill the FIFO, no third request
        mem_req_ready = 1'b1; inst_ready = 1'b0; rsp_en = 1'b1;
        start_test(32'h20);
        expect_inst(32'h20, 32'hAAAA_0000);
        expect_inst(32'h24, 32'hBBBB_0000);
        wait_pc_en(2, 30, "bp_req_count");
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_no_third_req", 64'(mem_req_valid), 64'd0);
            check("bp_full_valid", 64'(inst_valid), 64'd1);
            tick();
        end
        check("bp_no_pop", 64'(n_pops - pops_base), 64'd0);
        check("bp_pc_en", 64'(pc_en_cnt - pc_base), 64'd2);
        inst_ready = 1'b1; mem_req_ready = 1'b0;
        begin
            int k = 0;
            @(negedge clk);
            while (!mem_req_valid && k < 8) begin
                @(negedge clk);
                k++;
            end
        end
        check("bp_new_req", 64'(mem_req_valid), 64'd1);
        check("bp_new_req_addr", 64'(mem_req_addr), 64'h28);
        check("bp_pops_before_req", 64'(n_pops - pops_base), 64'd2);

        // Memory stall at 0x40
        mem_req_ready = 1'b0; inst_ready = 1'b1; rsp_en = 1'b1;
        start_test(32'h40);
        expect_inst(32'h40, 32'hD000_0040);
        @(negedge clk);
        check("stall_first_delay", 64'(mem_req_valid), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("stall_valid", 64'(mem_req_valid), 64'd1);
            check("stall_addr", 64'(mem_req_addr), 64'h40);
            check("stall_pc_en", 64'(pc_en), 64'd0);
        end
        tick();
        mem_req_ready = 1'b1;
        @(negedge clk);
        check("stall_accept_pc_en", 64'(pc_en), 64'd1);
        check("stall_accept_addr", 64'(mem_req_addr), 64'h40);
        tick();
        mem_req_ready = 1'b0;
        repeat (5) tick();
        check("stall_pc_en_total", 64'(pc_en_cnt - pc_base), 64'd1);
        check("stall_pops", 64'(n_pops - pops_base), 64'd1);

        // Flush while the 0x10 request is outstanding
        mem_req_ready = 1'b1; inst_ready = 1'b1; rsp_en = 1'b0;
        start_test(32'h10);
        expect_inst(32'h14, 32'hD000_0014);
        wait_pc_en(1, 10, "flush_req_count");
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("flush_wait_req", 64'(mem_req_valid), 64'd0);
        tick();
        flush = 1'b0; rsp_en = 1'b1;
        begin
            int k = 0;
            while ((pc_en_cnt - pc_base) < 2 && k < 15) begin
                @(negedge clk);
                check("flush_no_inst", 64'(inst_valid), 64'd0);
                tick();
                k++;
            end
        end
        check("flush_next_req", 64'(pc_en_cnt - pc_base), 64'd2);
        mem_req_ready = 1'b0;
        repeat (4) tick();
        check("flush_pops", 64'(n_pops - pops_base), 64'd1);

        // Push and pop on the same edge at occupancy 1
        mem_req_ready = 1'b1; inst_ready = 1'b0; rsp_en = 1'b1;
        start_test(32'h80);
        expect_inst(32'h80, 32'hD000_0080);
        expect_inst(32'h84, 32'hD000_0084);
        wait_pc_en(2, 20, "pp_req_count");
        mem_req_ready = 1'b0; inst_ready = 1'b1;
        @(negedge clk);
        check("pp_pre_valid", 64'(inst_valid), 64'd1);
        check("pp_rsp_present", 64'(mem_rsp_valid), 64'd1);
        tick();
        inst_ready = 1'b0;
        @(negedge clk);
        check("pp_occ_valid", 64'(inst_valid), 64'd1);
        check("pp_head_pc", 64'(inst_pc), 64'h84);
        tick();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        @(negedge clk);
        check("pp_occ_one", 64'(inst_valid), 64'd0);
        check("pp_pops", 64'(n_pops - pops_base), 64'd2);

        // Flush together with a push at occupancy 1
        mem_req_ready = 1'b1; inst_ready = 1'b0; rsp_en = 1'b1;
        start_test(32'hC0);
        wait_pc_en(2, 20, "fp_req_count");
        mem_req_ready = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("fp_pre_valid", 64'(inst_valid), 64'd1);
        check("fp_rsp_present", 64'(mem_rsp_valid), 64'd1);
        tick();
        flush = 1'b0; inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fp_empty", 64'(inst_valid), 64'd0);
            tick();
        end
        check("fp_pops", 64'(n_pops - pops_base), 64'd0);

        // Reset during WAIT, then a late response
        mem_req_ready = 1'b1; inst_ready = 1'b1; rsp_en = 1'b0;
        start_test(32'h100);
        wait_pc_en(1, 10, "rw_req_count");
        mem_req_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rw_rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rw_rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rw_rst_addr", 64'(mem_req_addr), 64'd0);
        tick();
        rst = 1'b0; rsp_en = 1'b1;
        m_rsp_valid = 1'b1; m_rsp_data = 32'hDEAD_0000;
        @(negedge clk);
        check("rw_late_idle", 64'(mem_req_valid), 64'd0);
        tick();
        m_rsp_valid = 1'b0;
        @(negedge clk);
        check("rw_late_inst", 64'(inst_valid), 64'd0);
        check("rw_idle_to_req", 64'(mem_req_valid), 64'd1);
        check("rw_req_addr", 64'(mem_req_addr), 64'h104);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("rw_no_inst", 64'(inst_valid), 64'd0);
        end

        check("final_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
